rij_operand_wb_stage: RTL and testbench
=======================================

// Module: rij_operand_wb_stage
// PURPOSE
//  Operand-fetch and write-back stage wrapped around the 32-bit combinational ALU in the R/I-type CPU.
//  Decodes one instruction word and reads the 32x32 register file. Drives latched A/B/ALU_OP into the ALU,
//  captures F/ZF/OF, then writes the result back. Multi-cycle: one instruction in flight, start/done handshake.
// PARAMETERS
//  DATA_W     32  datapath width; fixed at 32 to match the ALU
//  CLR_ON_RST 1   1 = register file cleared by reset; 0 = register file contents untouched by reset
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   begin executing inst; sampled only in IDLE
//  inst      in   32  instruction word, sampled in the cycle start is accepted
//  busy      out  1   high whenever state != IDLE
//  done      out  1   one-cycle pulse in the WB state
//  ill_inst  out  1   valid with done; opcode/funct not supported, no write performed
//  alu_a     out  32  ALU operand A (registered)
//  alu_b     out  32  ALU operand B (registered)
//  alu_op    out  3   ALU function select (registered)
//  alu_f     in   32  ALU result
//  alu_zf    in   1   ALU zero flag
//  alu_of    in   1   ALU overflow flag
//  zf        out  1   ZF captured from the last executed instruction
//  of        out  1   OF captured from the last executed instruction
//  dbg_addr  in   5   debug read address
//  dbg_data  out  32  register file [dbg_addr], combinational; 0 when dbg_addr==0
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, ill_inst=0, alu_a=alu_b=0, alu_op=3'b000, zf=of=0;
//    regs cleared if CLR_ON_RST. Reset mid-instruction aborts it: no write, no done.
//  FSM: IDLE -start-> DECODE -> EXEC -> WB -> IDLE. start is ignored outside IDLE.
//  Timing: start=1 at edge N; DECODE N..N+1; EXEC N+1..N+2; WB N+2..N+3, done=1 in WB. Next start accepted in IDLE.
//  IDLE edge with start=1: latch inst into an internal register.
//  DECODE edge: latch alu_a=R[rs], alu_b=R[rt] or imm, alu_op, dest, ill.
//    Fields: rs=inst[25:21], rt=inst[20:16], rd=inst[15:11].
//  R-type (op 000000), dest=rd, alu_a=R[rs], alu_b=R[rt]:
//    funct 100100 and->000, 100101 or->001, 100110 xor->010, 100111 nor->011, 100000 add->100,
//    100010 sub->101, 101011 sltu->110, 000100 sllv->111 (F=R[rt]<<R[rs]).
//  I-type, dest=rt, alu_a=R[rs], alu_b=ext(inst[15:0]):
//    001100 andi->000 zero-ext; 001101 ori->001 zero-ext; 001110 xori->010 zero-ext;
//    001000 addi->100 sign-ext; 001011 sltiu->110 sign-ext.
//  Anything else sets ill=1, alu_op=000, alu_a=alu_b=0.
//  EXEC edge: capture alu_f into a result register; zf<=alu_zf; of<=alu_of. Flags update even when ill.
//  WB edge: if !ill and dest!=0, R[dest]<=result. Writes to R0 are discarded; R0 always reads 0.
//  Overflow does not suppress write-back; of reports it.
//  Register reads in DECODE see all prior WB writes; dbg_data reflects a write the cycle after the WB edge.
//  ill_inst equals ill during WB and is 0 elsewhere.
//  alu_a/alu_b/alu_op hold their values after WB until the next DECODE.
// TESTING
//  1 Reset with CLR_ON_RST=1: all 32 dbg_data reads =0; busy=0; zf=of=0; reset mid-EXEC -> no write, done never pulses.
//  2 Execute ori r1,r0,0xFFFF then addi r2,r0,-1:
//    R1=0000FFFF, R2=FFFFFFFF; done exactly 3 cycles after each start; start pulsed while busy is ignored.
//  3 Load R1=7FFFFFFF, R2=1 via ori/addi, then add r3,r1,r2:
//    R3=80000000, of=1, zf=0; sub r4,r1,r1 -> R4=0, zf=1, of=0.
//  4 Execute sltu r5,r2,r1 -> R5=1; sllv r6,r2,r1 with R1[4:0]... use R7=4:
//    sllv r6,r7,r2 -> R6=R7<<R2=8; nor r8,r0,r0 -> R8=FFFFFFFF.
//  5 Execute add r0,r1,r2 -> R0 stays 0. Execute opcode 111111 -> ill_inst=1 with done, no register changes.
//  6 Back-to-back: start held high continuously for 4 instructions -> one accepted per 4 cycles, results in order.

Source files
------------

// File: rtl/rij_operand_wb_stage_if.sv
// -----------------------------------------------------------------------------
// rij_operand_wb_stage_if
// Bundles the handshake, ALU and debug signals of the operand-fetch /
// write-back stage.
//   start, inst            : request a new instruction (controller -> stage)
//   busy, done, ill_inst   : status (stage -> controller)
//   alu_a, alu_b, alu_op   : registered operands/function to the external ALU
//   alu_f, alu_zf, alu_of  : combinational ALU result and flags
//   zf, of                 : flags captured from the last executed instruction
//   dbg_addr, dbg_data     : combinational register-file debug read port
// slave  = the stage itself, master = the surrounding CPU/ALU environment.
// -----------------------------------------------------------------------------
interface rij_operand_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [31:0]       inst;
    logic              busy;
    logic              done;
    logic              ill_inst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_f;
    logic              alu_zf;
    logic              alu_of;
    logic              zf;
    logic              of;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  start, inst, alu_f, alu_zf, alu_of, dbg_addr,
        output busy, done, ill_inst, alu_a, alu_b, alu_op, zf, of, dbg_data
    );

    modport master (
        output start, inst, alu_f, alu_zf, alu_of, dbg_addr,
        input  busy, done, ill_inst, alu_a, alu_b, alu_op, zf, of, dbg_data
    );
endinterface

// File: rtl/rij_operand_wb_stage.sv
// -----------------------------------------------------------------------------
// rij_operand_wb_stage
// Operand-fetch and write-back stage around a 32-bit combinational ALU.
// One instruction in flight: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//   IDLE   : accept start, latch the instruction word
//   DECODE : read R[rs]/R[rt], build operand B (register or extended imm),
//            select ALU function, destination and illegal flag
//   EXEC   : capture ALU result and flags
//   WB     : done pulse; write result to R[dest] unless illegal or dest==0
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rij_operand_wb_stage_if.slave (handshake, ALU, debug)
// Parameters:
//   DATA_W     : datapath width (32 to match the ALU)
//   CLR_ON_RST : 1 clears the register file on reset, 0 leaves it untouched
// -----------------------------------------------------------------------------
module rij_operand_wb_stage #(
    parameter int DATA_W     = 32,
    parameter bit CLR_ON_RST = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    rij_operand_wb_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_inst;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_dest;
    logic              r_ill;
    logic              r_zf;
    logic              r_of;
    logic [DATA_W-1:0] r_regs [0:31];

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_imm_zx;
    logic [DATA_W-1:0] w_imm_sx;
    logic [DATA_W-1:0] w_dec_a;
    logic [DATA_W-1:0] w_dec_b;
    logic [2:0]        w_dec_op;
    logic [4:0]        w_dec_dest;
    logic              w_dec_ill;
    logic              w_wb_we;
    logic              w_unused_shamt;

    assign w_opcode       = r_inst[31:26];
    assign w_rs           = r_inst[25:21];
    assign w_rt           = r_inst[20:16];
    assign w_rd           = r_inst[15:11];
    assign w_funct        = r_inst[5:0];
    assign w_imm          = r_inst[15:0];
    // shamt field is not used by any supported instruction
    assign w_unused_shamt = ^r_inst[10:6];

    // R0 is never written, so reads of address 0 are forced to zero
    assign w_rs_data = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
    assign w_imm_zx  = {{(DATA_W-16){1'b0}}, w_imm};
    assign w_imm_sx  = {{(DATA_W-16){w_imm[15]}}, w_imm};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy     = (r_state != S_IDLE);
        bus.done     = (r_state == S_WB);
        bus.ill_inst = (r_state == S_WB) && r_ill;
    end

    // ---------------- Instruction decode ----------------
    always_comb begin
        w_dec_a    = w_rs_data;
        w_dec_b    = w_rt_data;
        w_dec_op   = 3'b000;
        w_dec_dest = w_rd;
        w_dec_ill  = 1'b0;
        if (w_opcode == 6'b000000) begin
            case (w_funct)
                6'b100100: w_dec_op = 3'b000;   // and
                6'b100101: w_dec_op = 3'b001;   // or
                6'b100110: w_dec_op = 3'b010;   // xor
                6'b100111: w_dec_op = 3'b011;   // nor
                6'b100000: w_dec_op = 3'b100;   // add
                6'b100010: w_dec_op = 3'b101;   // sub
                6'b101011: w_dec_op = 3'b110;   // sltu
                6'b000100: w_dec_op = 3'b111;   // sllv: ALU shifts B by A
                default:   w_dec_ill = 1'b1;
            endcase
        end else begin
            w_dec_dest = w_rt;
            case (w_opcode)
                6'b001100: begin w_dec_op = 3'b000; w_dec_b = w_imm_zx; end  // andi
                6'b001101: begin w_dec_op = 3'b001; w_dec_b = w_imm_zx; end  // ori
                6'b001110: begin w_dec_op = 3'b010; w_dec_b = w_imm_zx; end  // xori
                6'b001000: begin w_dec_op = 3'b100; w_dec_b = w_imm_sx; end  // addi
                6'b001011: begin w_dec_op = 3'b110; w_dec_b = w_imm_sx; end  // sltiu
                default:   w_dec_ill = 1'b1;
            endcase
        end
        if (w_dec_ill) begin
            w_dec_a  = '0;
            w_dec_b  = '0;
            w_dec_op = 3'b000;
        end
    end

    // ---------------- Instruction / operand / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst   <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 3'b000;
            r_result <= '0;
            r_dest   <= 5'd0;
            r_ill    <= 1'b0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_inst <= bus.inst;
            end
            // operands stay on the ALU inputs until the next decode
            if (r_state == S_DECODE) begin
                r_alu_a  <= w_dec_a;
                r_alu_b  <= w_dec_b;
                r_alu_op <= w_dec_op;
                r_dest   <= w_dec_dest;
                r_ill    <= w_dec_ill;
            end
            // flags are captured even for illegal instructions
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_f;
                r_zf     <= bus.alu_zf;
                r_of     <= bus.alu_of;
            end
        end
    end

    // ---------------- Register file write-back ----------------
    assign w_wb_we = (r_state == S_WB) && !r_ill && (r_dest != 5'd0);

    generate
        if (CLR_ON_RST) begin : g_rf_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) begin
                        r_regs[i] <= '0;
                    end
                end else if (w_wb_we) begin
                    r_regs[r_dest] <= r_result;
                end
            end
        end else begin : g_rf_keep
            // reset only aborts the FSM; stored values survive
            always_ff @(posedge clk) begin
                if (w_wb_we) begin
                    r_regs[r_dest] <= r_result;
                end
            end
        end
    endgenerate

    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_op   = r_alu_op;
    assign bus.zf       = r_zf;
    assign bus.of       = r_of;
    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : r_regs[bus.dbg_addr];
endmodule

// File: tb/tb_rij_operand_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_rij_operand_wb_stage
// Bench for the operand-fetch / write-back stage. Supplies a combinational
// ALU, runs a directed vector table, hand-written reset / back-to-back
// sequences and randomized instructions against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_rij_operand_wb_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rij_operand_wb_stage_if bus ();

    rij_operand_wb_stage #(
        .DATA_W    (32),
        .CLR_ON_RST(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- Combinational ALU ----------------
    logic [31:0] alu_f_c;
    logic        alu_of_c;
    always_comb begin
        alu_f_c  = 32'h0;
        alu_of_c = 1'b0;
        case (bus.alu_op)
            3'b000: alu_f_c = bus.alu_a & bus.alu_b;
            3'b001: alu_f_c = bus.alu_a | bus.alu_b;
            3'b010: alu_f_c = bus.alu_a ^ bus.alu_b;
            3'b011: alu_f_c = ~(bus.alu_a | bus.alu_b);
            3'b100: begin
                alu_f_c  = bus.alu_a + bus.alu_b;
                alu_of_c = (bus.alu_a[31] == bus.alu_b[31]) && (alu_f_c[31] != bus.alu_a[31]);
            end
            3'b101: begin
                alu_f_c  = bus.alu_a - bus.alu_b;
                alu_of_c = (bus.alu_a[31] != bus.alu_b[31]) && (alu_f_c[31] != bus.alu_a[31]);
            end
            3'b110: alu_f_c = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: alu_f_c = bus.alu_b << bus.alu_a;
        endcase
    end
    assign bus.alu_f  = alu_f_c;
    assign bus.alu_zf = (alu_f_c == 32'h0);
    assign bus.alu_of = alu_of_c;

    // ---------------- Bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- Instruction encoders ----------------
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // ---------------- Instruction-level reference model ----------------
    logic [31:0] mreg [32];

    task automatic model_exec(input logic [31:0] ins, output logic [4:0] dst, output logic [31:0] res,
                              output logic ezf, output logic eof, output logic eill);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sx;
        logic [31:0] zx;
        longint      s;
        op   = ins[31:26];
        fn   = ins[5:0];
        a    = mreg[ins[25:21]];
        zx   = {16'h0, ins[15:0]};
        sx   = {{16{ins[15]}}, ins[15:0]};
        res  = 32'h0;
        eof  = 1'b0;
        eill = 1'b0;
        if (op == 6'd0) begin
            dst = ins[15:11];
            b   = mreg[ins[20:16]];
            case (fn)
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h20: begin
                    s = longint'($signed(a)) + longint'($signed(b));
                    res = s[31:0];
                    eof = (s != longint'($signed(res)));
                end
                6'h22: begin
                    s = longint'($signed(a)) - longint'($signed(b));
                    res = s[31:0];
                    eof = (s != longint'($signed(res)));
                end
                6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                6'h04: res = b << a;
                default: eill = 1'b1;
            endcase
        end else begin
            dst = ins[20:16];
            case (op)
                6'h0C: res = a & zx;
                6'h0D: res = a | zx;
                6'h0E: res = a ^ zx;
                6'h08: begin
                    s = longint'($signed(a)) + longint'($signed(sx));
                    res = s[31:0];
                    eof = (s != longint'($signed(res)));
                end
                6'h0B: res = (a < sx) ? 32'd1 : 32'd0;
                default: eill = 1'b1;
            endcase
        end
        if (eill) begin
            res = 32'h0;
            eof = 1'b0;
            dst = 5'd0;
        end
        ezf = (res == 32'h0);
        if (!eill && dst != 5'd0) mreg[dst] = res;
    endtask

    // ---------------- Drive one instruction through the stage ----------------
    task automatic exec_inst(input logic [31:0] ins, input bit poke, output int lat,
                             output logic ozf, output logic oof, output logic oill);
        @(negedge clk);
        bus.start = 1'b1;
        bus.inst  = ins;
        @(negedge clk);
        // a start raised here must be ignored (stage already busy)
        bus.start = poke;
        bus.inst  = poke ? 32'h2001_1234 : 32'hFFFF_FFFF;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
        end
        ozf  = bus.zf;
        oof  = bus.of;
        oill = bus.ill_inst;
        @(negedge clk);
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        bus.dbg_addr = 5'(r);
        #1;
        v = bus.dbg_data;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] v;
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            chk($sformatf("%s R%0d", tag, r), v, mreg[r]);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        int          rchk;
        logic [31:0] val;
        logic        zf;
        logic        of;
        logic        ill;
        bit          poke;
        string       nm;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [31:0] i, input int r, input logic [31:0] v,
                                input logic z, input logic o, input logic il, input bit p, input string n);
        vec_t t;
        t.inst = i; t.rchk = r; t.val = v; t.zf = z; t.of = o; t.ill = il; t.poke = p; t.nm = n;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  dst;
        logic [31:0] res;
        logic [31:0] v;
        logic        ezf, eof, eill, ozf, oof, oill;
        int          lat;
        int          cnt0;
        logic [31:0] b2b [4];
        int          dcyc [$];
        int          k, cyc;

        for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
        bus.start = 1'b0;
        bus.inst = 32'h0;
        bus.dbg_addr = 5'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- Reset state ----------------
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst ill", 32'(bus.ill_inst), 32'd0);
        chk("rst zf", 32'(bus.zf), 32'd0);
        chk("rst of", 32'(bus.of), 32'd0);
        chk("rst alu_a", bus.alu_a, 32'h0);
        chk("rst alu_b", bus.alu_b, 32'h0);
        chk("rst alu_op", 32'(bus.alu_op), 32'd0);
        compare_all("rst");

        // ---------------- Reset during EXEC aborts the instruction ----------------
        @(negedge clk);
        bus.start = 1'b1;
        bus.inst  = itype(6'h0D, 0, 1, 16'hFFFF);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        cnt0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort no done", 32'(done_cnt), 32'(cnt0));
        read_reg(1, v);
        chk("abort R1", v, 32'h0);

        // ---------------- Directed vector table ----------------
        tv.push_back(mk(itype(6'h0D, 0, 1, 16'hFFFF), 1, 32'h0000FFFF, 0, 0, 0, 1, "ori r1"));
        tv.push_back(mk(itype(6'h08, 0, 2, 16'hFFFF), 2, 32'hFFFFFFFF, 0, 0, 0, 1, "addi r2 -1"));
        tv.push_back(mk(itype(6'h08, 0, 2, 16'h0001), 2, 32'h00000001, 0, 0, 0, 0, "addi r2 1"));
        tv.push_back(mk(itype(6'h08, 0, 9, 16'h001F), 9, 32'h0000001F, 0, 0, 0, 0, "addi r9 31"));
        tv.push_back(mk(rtype(9, 2, 10, 6'h04), 10, 32'h80000000, 0, 0, 0, 0, "sllv r10"));
        tv.push_back(mk(rtype(10, 0, 1, 6'h27), 1, 32'h7FFFFFFF, 0, 0, 0, 0, "nor r1"));
        tv.push_back(mk(rtype(1, 2, 3, 6'h20), 3, 32'h80000000, 0, 1, 0, 0, "add ovf r3"));
        tv.push_back(mk(rtype(1, 1, 4, 6'h22), 4, 32'h00000000, 1, 0, 0, 0, "sub r4"));
        tv.push_back(mk(rtype(2, 1, 5, 6'h2B), 5, 32'h00000001, 0, 0, 0, 0, "sltu r5"));
        tv.push_back(mk(itype(6'h08, 0, 7, 16'h0004), 7, 32'h00000004, 0, 0, 0, 0, "addi r7"));
        tv.push_back(mk(rtype(2, 7, 6, 6'h04), 6, 32'h00000008, 0, 0, 0, 0, "sllv r6"));
        tv.push_back(mk(rtype(0, 0, 8, 6'h27), 8, 32'hFFFFFFFF, 0, 0, 0, 0, "nor r8"));
        tv.push_back(mk(rtype(1, 2, 0, 6'h20), 0, 32'h00000000, 0, 1, 0, 0, "add r0"));
        tv.push_back(mk(32'hFC22_0000, 1, 32'h7FFFFFFF, 1, 0, 1, 0, "ill opcode"));
        tv.push_back(mk(itype(6'h0C, 1, 11, 16'h00F0), 11, 32'h000000F0, 0, 0, 0, 0, "andi r11"));
        tv.push_back(mk(itype(6'h0E, 11, 12, 16'h00FF), 12, 32'h0000000F, 0, 0, 0, 0, "xori r12"));
        tv.push_back(mk(itype(6'h0B, 11, 13, 16'hFFFF), 13, 32'h00000001, 0, 0, 0, 0, "sltiu r13"));
        tv.push_back(mk(rtype(1, 10, 14, 6'h24), 14, 32'h00000000, 1, 0, 0, 0, "and r14"));
        tv.push_back(mk(rtype(1, 10, 15, 6'h25), 15, 32'hFFFFFFFF, 0, 0, 0, 0, "or r15"));
        tv.push_back(mk(rtype(1, 8, 16, 6'h26), 16, 32'h80000000, 0, 0, 0, 0, "xor r16"));
        tv.push_back(mk(rtype(1, 2, 17, 6'h3F), 17, 32'h00000000, 1, 0, 1, 0, "ill funct"));

        foreach (tv[i]) begin
            model_exec(tv[i].inst, dst, res, ezf, eof, eill);
            exec_inst(tv[i].inst, tv[i].poke, lat, ozf, oof, oill);
            chk({tv[i].nm, " done latency"}, 32'(lat), 32'd3);
            chk({tv[i].nm, " zf"}, 32'(ozf), 32'(tv[i].zf));
            chk({tv[i].nm, " of"}, 32'(oof), 32'(tv[i].of));
            chk({tv[i].nm, " ill_inst"}, 32'(oill), 32'(tv[i].ill));
            chk({tv[i].nm, " idle"}, {30'd0, bus.busy, bus.ill_inst}, 32'd0);
            read_reg(tv[i].rchk, v);
            chk({tv[i].nm, " value"}, v, tv[i].val);
        end
        compare_all("table");

        // ---------------- Back-to-back with start held high ----------------
        b2b[0] = itype(6'h08, 0, 18, 16'h0005);
        b2b[1] = itype(6'h08, 18, 19, 16'h0003);
        b2b[2] = rtype(18, 19, 20, 6'h20);
        b2b[3] = rtype(20, 18, 21, 6'h22);
        @(negedge clk);
        bus.start = 1'b1;
        bus.inst  = b2b[0];
        k = 1;
        cyc = 0;
        while (k <= 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                dcyc.push_back(cyc);
                if (k < 4) bus.inst = b2b[k];
                k++;
            end
        end
        bus.start = 1'b0;
        chk("b2b done count", 32'(dcyc.size()), 32'd4);
        for (int i = 0; i < dcyc.size(); i++) begin
            chk($sformatf("b2b done cycle %0d", i), 32'(dcyc[i]), 32'(3 + 4 * i));
        end
        for (int i = 0; i < 4; i++) model_exec(b2b[i], dst, res, ezf, eof, eill);
        repeat (2) @(negedge clk);
        chk("b2b idle", 32'(bus.busy), 32'd0);
        for (int r = 18; r <= 21; r++) begin
            read_reg(r, v);
            chk($sformatf("b2b R%0d", r), v, mreg[r]);
        end

        // ---------------- Randomized instructions vs model ----------------
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            int          kind;
            int          rs, rt, rd;
            logic [15:0] imm;
            kind = $urandom_range(0, 13);
            rs   = $urandom_range(0, 21);
            rt   = $urandom_range(0, 21);
            rd   = $urandom_range(0, 21);
            imm  = 16'($urandom);
            case (kind)
                0:  ins = rtype(rs, rt, rd, 6'h24);
                1:  ins = rtype(rs, rt, rd, 6'h25);
                2:  ins = rtype(rs, rt, rd, 6'h26);
                3:  ins = rtype(rs, rt, rd, 6'h27);
                4:  ins = rtype(rs, rt, rd, 6'h20);
                5:  ins = rtype(rs, rt, rd, 6'h22);
                6:  ins = rtype(rs, rt, rd, 6'h2B);
                7:  ins = rtype(rs, rt, rd, 6'h04);
                8:  ins = itype(6'h0C, rs, rt, imm);
                9:  ins = itype(6'h0D, rs, rt, imm);
                10: ins = itype(6'h0E, rs, rt, imm);
                11: ins = itype(6'h08, rs, rt, imm);
                12: ins = itype(6'h0B, rs, rt, imm);
                default: ins = {6'h3F, 26'($urandom)};
            endcase
            model_exec(ins, dst, res, ezf, eof, eill);
            exec_inst(ins, 1'b0, lat, ozf, oof, oill);
            chk($sformatf("rnd%0d latency", n), 32'(lat), 32'd3);
            chk($sformatf("rnd%0d zf", n), 32'(ozf), 32'(ezf));
            chk($sformatf("rnd%0d of", n), 32'(oof), 32'(eof));
            chk($sformatf("rnd%0d ill", n), 32'(oill), 32'(eill));
            read_reg(int'(dst), v);
            chk($sformatf("rnd%0d R%0d", n, dst), v, mreg[dst]);
        end
        compare_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
